f_mant_normalizer: RTL and testbench
====================================

// Module: f_mant_normalizer
// PURPOSE
//  Post-add normalize stage of the FP32 datapath: takes the raw sign/exponent/25-bit
//  magnitude from the mantissa adder and produces a packed IEEE-754 single.
//  Uses F_priority_encoder for leading-one detection.
//  2-stage pipeline with valid/ready handshake; feeds the FP result register.
// PARAMETERS
//  FLUSH_DENORM  0  1: subnormal results flush to signed zero (zero=1); 0: emit subnormal
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   asynchronous, active-high; clears pipeline valids
//  in_valid   in   1   input beat present
//  in_ready   out  1   stage can accept input this cycle
//  in_sign    in   1   result sign
//  in_exp     in   8   biased exponent of weight of m[23]; 0 treated as 1
//  in_mant    in   25  magnitude; m[24]=carry, m[23]=hidden-one position
//  out_valid  out  1   result present
//  out_ready  in   1   consumer accepts result
//  out_result out  32  packed FP32 {sign, exp[7:0], frac[22:0]}
//  out_zero   out  1   result magnitude is zero
//  out_ovf    out  1   overflow to infinity
//  out_inexact out 1   nonzero bit discarded by right shift
// BEHAVIOUR
//  Reset: out_valid=0, out_result=0, all flags 0, in_ready=1; internal valids cleared
//   immediately. In-flight beats are discarded, not completed.
//  Handshake: a beat transfers when valid&ready are both high. Stage k loads when empty or
//   when stage k+1 loads this cycle. in_ready = !s1_valid | s2_load.
//   Fully pipelined: 1 beat/cycle when out_ready=1. Latency is 2 cycles from input transfer
//   to out_valid. Outputs hold stable while out_valid & !out_ready. Order is preserved.
//  S1 classify (e = in_exp==0 ? 1 : in_exp):
//   in_exp==255:  pass-through; exp=255, frac=m[22:0], no flags.
//   m[24]=1:      shift right 1, exp=e+1, inexact=m[0]; if e+1>=255: exp=255, frac=0, ovf=1.
//   m[23]=1:      no shift, exp=e.
//   m==0:         result {sign,31'b0}, zero=1.
//   else:         y=F_priority_encoder(m[22:0]), lz=24-y (1..23).
//                 If e>lz: shift left lz, exp=e-lz.
//                 Else subnormal: shift left e-1, exp=0.
//                 With FLUSH_DENORM=1: {sign,31'b0}, zero=1.
//  S1 register holds: sign, exp, shift dir/amount (5b), class, raw mant.
//  S2 performs the barrel shift (left 0..23 or right 1) and packs.
//   frac = shifted[22:0]; the hidden bit is dropped.
//  Rounding: truncation only; rounding belongs to the downstream stage.
//  Exponent arithmetic is 9-bit internal, so no wrap at 255/0.
//  Simultaneous S2 drain and S1 load in one cycle is legal and loses no beats.
// STRUCTURE
//  f_pkg: FP32_EXP_W=8, FP32_FRAC_W=23, EXP_INF=8'hFF.
//   typedef fp32_t packed struct {sign, exp, frac}.
//   typedef enum norm_class_e {NC_PASS, NC_CARRY, NC_NORM, NC_LSHIFT, NC_ZERO, NC_SUBN}.
//  Sub-module: one F_priority_encoder instance in S1.
//  Shift and pack logic stays inline in S2.
// TESTING
//  1 exp=127, m=0x0800000 -> 0x3F800000, no flags, out_valid 2 cycles after transfer.
//  2 exp=127, m=0x1000001 (carry) -> 0x40000000, inexact=1.
//    exp=254, m=0x1000000 -> 0x7F800000, ovf=1.
//  3 exp=127, m=0x0000001 -> 0x34000000.
//    sign=1, m=0 -> 0x80000000, zero=1.
//  4 exp=5, m=0x0000100 -> 0x00001000 (subnormal).
//    Same input with FLUSH_DENORM=1 -> 0x00000000, zero=1.
//  5 Back-to-back stream of 4 beats with out_ready low for 3 cycles:
//    in_ready drops after 2 beats held, no loss or reorder, throughput returns to 1/cycle.
//  6 reset asserted mid-stream (async, between edges):
//    out_valid=0 and in_ready=1 immediately; no stale beat after release.

Source files
------------

// File: rtl/f_pkg.sv
// rtl/f_pkg.sv - shared FP32 types and constants for the normalize stage
//
// Purpose: field widths, the packed FP32 layout and the normalize classes
// that S1 hands to S2.
package f_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam logic [FP32_EXP_W-1:0] EXP_INF = 8'hFF;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    NC_PASS,
    NC_CARRY,
    NC_NORM,
    NC_LSHIFT,
    NC_ZERO,
    NC_SUBN
  } norm_class_e;

endpackage

// File: rtl/F_priority_encoder.sv
// rtl/F_priority_encoder.sv - leading-one detector for the mantissa normalizer
//
// Purpose: reports the position of the most significant set bit.
// Ports:
//   req_i    WIDTH  input vector
//   pos_o    POS_W  1-based index of the highest set bit (0 when none set)
//   found_o  1      any bit set
module F_priority_encoder #(
  parameter int WIDTH = 23,
  parameter int POS_W = 5
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [POS_W-1:0] pos_o,
  output logic             found_o
);

  always_comb begin
    pos_o   = '0;
    found_o = |req_i;
    // Ascending scan: the last hit written is the most significant one.
    for (int i = 0; i < WIDTH; i++) begin
      if (req_i[i]) begin
        pos_o = POS_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/f_mant_normalizer.sv
// rtl/f_mant_normalizer.sv - post-add normalize stage producing packed FP32
//
// Purpose: two-stage pipeline. S1 classifies the raw adder result and picks
// the shift; S2 applies the shift and packs sign/exponent/fraction.
// Ports:
//   clk, reset                    clock, async active-high reset
//   in_valid/in_ready             input handshake
//   in_sign, in_exp, in_mant      raw sign, biased exponent, 25-bit magnitude
//   out_valid/out_ready           output handshake
//   out_result                    packed FP32 {sign, exp, frac}
//   out_zero, out_ovf, out_inexact result flags
module f_mant_normalizer
  import f_pkg::*;
#(
  parameter bit FLUSH_DENORM = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_inexact
);

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_load, s2_load;

  assign s2_load  = !s2_valid_q | out_ready;
  assign s1_load  = !s1_valid_q | s2_load;
  assign in_ready = s1_load;

  // S1 classify
  logic [4:0]  pe_pos;
  logic        pe_found;
  logic [8:0]  e9, lz9, e_inc;
  logic [7:0]  s1_exp_d;
  logic        s1_shr_d;
  logic [4:0]  s1_amt_d;
  norm_class_e s1_cls_d;

  F_priority_encoder #(.WIDTH(23), .POS_W(5)) u_lod (
    .req_i   (in_mant[22:0]),
    .pos_o   (pe_pos),
    .found_o (pe_found)
  );

  // Exponent 0 carries the same weight as exponent 1 (subnormal input).
  assign e9    = (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
  assign lz9   = 9'd24 - {4'b0, pe_pos};
  assign e_inc = e9 + 9'd1;

  always_comb begin
    s1_cls_d = NC_NORM;
    s1_exp_d = e9[7:0];
    s1_shr_d = 1'b0;
    s1_amt_d = 5'd0;
    if (in_exp == EXP_INF) begin
      s1_cls_d = NC_PASS;
      s1_exp_d = EXP_INF;
    end else if (in_mant[24]) begin
      s1_cls_d = NC_CARRY;
      s1_shr_d = 1'b1;
      s1_amt_d = 5'd1;
      s1_exp_d = (e_inc >= 9'd255) ? EXP_INF : e_inc[7:0];
    end else if (in_mant[23]) begin
      s1_cls_d = NC_NORM;
    end else if (!pe_found) begin
      s1_cls_d = NC_ZERO;
      s1_exp_d = 8'd0;
    end else if (e9 > lz9) begin
      s1_cls_d = NC_LSHIFT;
      s1_amt_d = lz9[4:0];
      s1_exp_d = 8'(e9 - lz9);
    end else if (FLUSH_DENORM) begin
      s1_cls_d = NC_ZERO;
      s1_exp_d = 8'd0;
    end else begin
      // Shift only as far as the minimum exponent allows; the hidden-bit
      // position is never reached, so the result stays subnormal.
      s1_cls_d = NC_SUBN;
      s1_amt_d = 5'(e9 - 9'd1);
      s1_exp_d = 8'd0;
    end
  end

  // S1 register
  logic        s1_sign_q, s1_shr_q;
  logic [7:0]  s1_exp_q;
  logic [4:0]  s1_amt_q;
  logic [24:0] s1_mant_q;
  norm_class_e s1_cls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= 8'd0;
      s1_shr_q   <= 1'b0;
      s1_amt_q   <= 5'd0;
      s1_cls_q   <= NC_ZERO;
      s1_mant_q  <= 25'd0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_exp_q  <= s1_exp_d;
        s1_shr_q  <= s1_shr_d;
        s1_amt_q  <= s1_amt_d;
        s1_cls_q  <= s1_cls_d;
        s1_mant_q <= in_mant;
      end
    end
  end

  // S2 shift and pack; truncation only, rounding happens downstream.
  logic [22:0] frac_sh;
  fp32_t       res_d, res_q;
  logic        zero_d, ovf_d, inx_d;
  logic        zero_q, ovf_q, inx_q;

  assign frac_sh = s1_shr_q ? s1_mant_q[23:1] : 23'(s1_mant_q << s1_amt_q);

  always_comb begin
    res_d  = '{sign: s1_sign_q, exp: s1_exp_q, frac: frac_sh};
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    inx_d  = 1'b0;
    case (s1_cls_q)
      NC_PASS: res_d.frac = s1_mant_q[22:0];
      NC_CARRY: begin
        inx_d = s1_mant_q[0];
        if (s1_exp_q == EXP_INF) begin
          ovf_d      = 1'b1;
          res_d.frac = 23'd0;
        end
      end
      NC_ZERO: begin
        zero_d = 1'b1;
        res_d  = '{sign: s1_sign_q, exp: 8'd0, frac: 23'd0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q  <= res_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
        inx_q  <= inx_d;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_inexact = inx_q;

endmodule

// File: tb/tb_f_mant_normalizer.sv
// tb/tb_f_mant_normalizer.sv - directed self-checking bench for f_mant_normalizer
module tb_f_mant_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sign, out_ready;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;

  logic        in_ready0, out_valid0, out_zero0, out_ovf0, out_inexact0;
  logic [31:0] out_result0;
  logic        in_ready1, out_valid1, out_zero1, out_ovf1, out_inexact1;
  logic [31:0] out_result1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  f_mant_normalizer #(.FLUSH_DENORM(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_result(out_result0), .out_zero(out_zero0),
    .out_ovf(out_ovf0), .out_inexact(out_inexact0)
  );

  f_mant_normalizer #(.FLUSH_DENORM(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_result(out_result1), .out_zero(out_zero1),
    .out_ovf(out_ovf1), .out_inexact(out_inexact1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One isolated beat with out_ready=1; flags are {zero, ovf, inexact}.
  task automatic run(input string tag, input logic s, input logic [7:0] e,
                     input logic [24:0] m, input logic [31:0] r0, input logic [2:0] f0,
                     input logic [31:0] r1, input logic [2:0] f1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".early_valid"}, 32'(out_valid0), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid0"}, 32'(out_valid0), 32'd1);
    chk({tag, ".res0"}, out_result0, r0);
    chk({tag, ".flags0"}, 32'({out_zero0, out_ovf0, out_inexact0}), 32'(f0));
    chk({tag, ".valid1"}, 32'(out_valid1), 32'd1);
    chk({tag, ".res1"}, out_result1, r1);
    chk({tag, ".flags1"}, 32'({out_zero1, out_ovf1, out_inexact1}), 32'(f1));
  endtask

  logic [31:0] exp_q [4];
  int          rcv_cyc [4];
  logic        rdy_hist [8];
  int          sent, recv;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 25'd0;
    out_ready = 1'b1;
    #12;
    chk("reset.out_valid", 32'(out_valid0), 32'd0);
    chk("reset.in_ready", 32'(in_ready0), 32'd1);
    chk("reset.result", out_result0, 32'd0);
    chk("reset.flags", 32'({out_zero0, out_ovf0, out_inexact0}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("one",      1'b0, 8'd127, 25'h0800000, 32'h3F800000, 3'b000, 32'h3F800000, 3'b000);
    run("carry",    1'b0, 8'd127, 25'h1000001, 32'h40000000, 3'b001, 32'h40000000, 3'b001);
    run("ovf",      1'b0, 8'd254, 25'h1000000, 32'h7F800000, 3'b010, 32'h7F800000, 3'b010);
    run("lshift23", 1'b0, 8'd127, 25'h0000001, 32'h34000000, 3'b000, 32'h34000000, 3'b000);
    run("negzero",  1'b1, 8'd127, 25'h0000000, 32'h80000000, 3'b100, 32'h80000000, 3'b100);
    run("subn",     1'b0, 8'd5,   25'h0000100, 32'h00001000, 3'b000, 32'h00000000, 3'b100);
    run("pass",     1'b0, 8'd255, 25'h0400001, 32'h7FC00001, 3'b000, 32'h7FC00001, 3'b000);
    run("exp0norm", 1'b0, 8'd0,   25'h0800000, 32'h00800000, 3'b000, 32'h00800000, 3'b000);
    run("exp0subn", 1'b0, 8'd0,   25'h0000100, 32'h00000100, 3'b000, 32'h00000000, 3'b100);
    run("e_eq_lz",  1'b0, 8'd23,  25'h0000001, 32'h00400000, 3'b000, 32'h00000000, 3'b100);
    run("e_gt_lz",  1'b0, 8'd24,  25'h0000001, 32'h00800000, 3'b000, 32'h00800000, 3'b000);
    run("lshift1",  1'b1, 8'd2,   25'h0400000, 32'h80800000, 3'b000, 32'h80800000, 3'b000);

    // Drain, then a 4-beat stream with out_ready held low for 3 cycles.
    @(posedge clk); #1;
    chk("stream.idle", 32'(out_valid0), 32'd0);
    exp_q[0] = 32'h3F800000;
    exp_q[1] = 32'h40000000;
    exp_q[2] = 32'h40800000;
    exp_q[3] = 32'h41000000;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 20 && recv < 4; c++) begin
      out_ready = (c >= 3);
      in_valid  = (sent < 4);
      in_sign   = 1'b0;
      in_exp    = 8'(127 + sent);
      in_mant   = 25'h0800000;
      @(negedge clk);
      if (c < 8) rdy_hist[c] = in_ready0;
      if (out_valid0 && out_ready) begin
        chk($sformatf("stream.res%0d", recv), out_result0, exp_q[recv]);
        rcv_cyc[recv] = c;
        recv++;
      end
      if (in_valid && in_ready0) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream.count", 32'(recv), 32'd4);
    chk("stream.in_ready_held", 32'(rdy_hist[2]), 32'd0);
    chk("stream.in_ready_back", 32'(rdy_hist[3]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stream.cycle%0d", i), 32'(rcv_cyc[i]), 32'(3 + i));
    end

    // Reset asserted between edges with beats in flight.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_exp   = 8'd127;
    in_mant  = 25'h0800000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.pre_valid", 32'(out_valid0), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("rst.out_valid", 32'(out_valid0), 32'd0);
    chk("rst.in_ready", 32'(in_ready0), 32'd1);
    chk("rst.result", out_result0, 32'd0);
    chk("rst.out_valid1", 32'(out_valid1), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst.no_stale%0d", i), 32'(out_valid0), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
